// File: rtl/cozy_regdump.sv
// cozy_regdump: serialises a register-file range as a framed byte stream
// (header 0xA5, hi/lo bytes per register, XOR checksum) over valid/ready.
module cozy_regdump #(
   parameter int FIRST_REG = 1,
   parameter int LAST_REG  = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        busy,
   output logic [3:0]  rf_sel,
   input  logic [15:0] rf_data,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        done
);
   typedef enum logic [2:0] {IDLE, HDR, HI, LO, SUM} state_t;
   localparam logic [3:0] FIRST = 4'(FIRST_REG);
   localparam logic [3:0] LAST  = 4'(LAST_REG);
   state_t      state, state_nxt;
   logic [15:0] word, word_nxt;
   logic [7:0]  sum, sum_nxt, data_nxt;
   logic [3:0]  sel_nxt;
   logic        last, last_nxt, done_nxt, xfer;
   assign xfer = out_valid & out_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         word      <= '0;
         sum       <= '0;
         out_data  <= '0;
         rf_sel    <= '0;
         last      <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         word      <= word_nxt;
         sum       <= sum_nxt;
         out_data  <= data_nxt;
         rf_sel    <= sel_nxt;
         last      <= last_nxt;
         done      <= done_nxt;
         busy      <= state_nxt != IDLE;
         out_valid <= state_nxt != IDLE;
      end
   end
   // out_data is registered, so each transfer preloads the byte for the next state
   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      sum_nxt   = sum;
      data_nxt  = out_data;
      sel_nxt   = rf_sel;
      last_nxt  = last;
      done_nxt  = 1'b0;
      case (state)
         IDLE: if (start) begin
            state_nxt = HDR;
            sel_nxt   = FIRST;
            sum_nxt   = 8'hA5;
            data_nxt  = 8'hA5;
         end
         HDR: if (xfer) begin
            state_nxt = HI;
            word_nxt  = rf_data;
            last_nxt  = rf_sel == LAST;
            sel_nxt   = rf_sel + 4'd1;
            data_nxt  = rf_data[15:8];
         end
         HI: if (xfer) begin
            state_nxt = LO;
            sum_nxt   = sum ^ word[15:8];
            data_nxt  = word[7:0];
         end
         LO: if (xfer) begin
            sum_nxt   = sum ^ word[7:0];
            state_nxt = last ? SUM : HI;
            data_nxt  = last ? (sum ^ word[7:0]) : rf_data[15:8];
            word_nxt  = last ? word : rf_data;
            last_nxt  = last ? last : rf_sel == LAST;
            sel_nxt   = last ? rf_sel : rf_sel + 4'd1;
         end
         SUM: if (xfer) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            sel_nxt   = '0;
            data_nxt  = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_cozy_regdump.sv
// tb_cozy_regdump: scoreboard bench for three cozy_regdump configurations
// sharing one register-file model.
module tb_cozy_regdump;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_v [3];
   logic        busy_v  [3];
   logic [3:0]  sel_v   [3];
   logic [15:0] rfd     [3];
   logic [7:0]  od      [3];
   logic        ov      [3];
   logic        rdy     [3];
   logic        done_v  [3];
   logic [15:0] rf  [16];
   logic [15:0] mdl [16];
   logic [7:0]  q [$];
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   for (genvar k = 0; k < 3; k++) begin : g_rf
      assign rfd[k] = (sel_v[k] == 4'd0) ? 16'h0000 : rf[sel_v[k]];
   end
   cozy_regdump u0 (.clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]),
      .rf_sel(sel_v[0]), .rf_data(rfd[0]), .out_data(od[0]), .out_valid(ov[0]),
      .out_ready(rdy[0]), .done(done_v[0]));
   cozy_regdump #(.FIRST_REG(1), .LAST_REG(1)) u1 (.clk(clk), .rst_n(rst_n),
      .start(start_v[1]), .busy(busy_v[1]), .rf_sel(sel_v[1]), .rf_data(rfd[1]),
      .out_data(od[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .done(done_v[1]));
   cozy_regdump #(.FIRST_REG(0), .LAST_REG(0)) u2 (.clk(clk), .rst_n(rst_n),
      .start(start_v[2]), .busy(busy_v[2]), .rf_sel(sel_v[2]), .rf_data(rfd[2]),
      .out_data(od[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .done(done_v[2]));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic void push_frame(input int first, input int last);
      logic [7:0]  c;
      logic [15:0] w;
      c = 8'hA5;
      q.push_back(8'hA5);
      for (int r = first; r <= last; r++) begin
         w = (r == 0) ? 16'h0000 : mdl[r];
         q.push_back(w[15:8]);
         q.push_back(w[7:0]);
         c = c ^ w[15:8] ^ w[7:0];
      end
      q.push_back(c);
   endfunction
   // pulses start on DUT d, then compares every transferred byte with the queue
   task automatic run(input int d, input bit bp, input bit snap, input int abort_n,
                      output int nbytes, output int nbusy, output int ndone, output int gap);
      int cyc, last_x, done_cyc;
      bit held;
      logic [7:0] hv, exp;
      cyc = 0; last_x = -100; done_cyc = -1; held = 0; hv = '0;
      nbytes = 0; nbusy = 0; ndone = 0; gap = -1;
      @(posedge clk); #1 start_v[d] = 1'b1; rdy[d] = 1'b1;
      @(posedge clk); #1 start_v[d] = 1'b0;
      while (cyc < 600) begin
         @(negedge clk);
         if (cyc == 0) chk("first_valid", {ov[d], od[d]}, {1'b1, 8'hA5});
         if (busy_v[d]) nbusy++;
         if (done_v[d]) begin
            ndone++;
            done_cyc = cyc;
            gap = cyc - last_x;
         end
         if (held) chk("hold_stable", {ov[d], od[d]}, {1'b1, hv});
         held = ov[d] & ~rdy[d];
         hv = od[d];
         if (ov[d] & rdy[d]) begin
            exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
            chk("byte", od[d], exp);
            nbytes++;
            last_x = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         if (abort_n > 0 && nbytes == abort_n) break;
         @(posedge clk); #1;
         if (bp) rdy[d] = 1'($urandom_range(0, 1));
         if (snap && nbytes == 1) begin
            rf[1] = 16'h1234;
            rf[2] = 16'h5678;
         end
         cyc++;
      end
   endtask
   initial begin
      int nb, nbusy, nd, gap;
      for (int k = 0; k < 3; k++) begin
         start_v[k] = 1'b0;
         rdy[k] = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
         rf[i] = 16'(i * 16'h1111);
         mdl[i] = rf[i];
      end
      #2;
      chk("rst_outputs", {ov[0], busy_v[0], done_v[0], od[0], sel_v[0]}, 15'h0);
      chk("rst_small", {ov[1], ov[2], busy_v[1], busy_v[2]}, 4'h0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      // full default frame, no backpressure
      push_frame(1, 15);
      run(0, 0, 0, 0, nb, nbusy, nd, gap);
      chk("s1_bytes", nb, 32);
      chk("s1_busy_cycles", nbusy, 32);
      chk("s1_done_count", nd, 1);
      chk("s1_done_gap", gap, 1);
      chk("s1_queue_empty", q.size(), 0);
      // single register R1=0xAA55
      rf[1] = 16'hAA55;
      q.push_back(8'hA5); q.push_back(8'hAA); q.push_back(8'h55); q.push_back(8'h5A);
      run(1, 0, 0, 0, nb, nbusy, nd, gap);
      chk("s2_bytes", nb, 4);
      chk("s2_done_count", nd, 1);
      rf[1] = 16'h1111;
      // R0 only: always reads zero
      q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'hA5);
      run(2, 0, 0, 0, nb, nbusy, nd, gap);
      chk("s3_bytes", nb, 4);
      chk("s3_done_count", nd, 1);
      // random backpressure, same default stream
      push_frame(1, 15);
      run(0, 1, 0, 0, nb, nbusy, nd, gap);
      chk("s4_bytes", nb, 32);
      chk("s4_done_count", nd, 1);
      rdy[0] = 1'b1;
      // snapshot: R1 already latched, R2 write lands before its capture
      mdl[2] = 16'h5678;
      push_frame(1, 15);
      run(0, 0, 1, 0, nb, nbusy, nd, gap);
      chk("s5_bytes", nb, 32);
      chk("s5_done_count", nd, 1);
      rf[1] = 16'h1111; rf[2] = 16'h2222; mdl[2] = 16'h2222;
      // reset mid-frame
      push_frame(1, 15);
      run(0, 0, 0, 5, nb, nbusy, nd, gap);
      chk("s6_partial", nb, 5);
      rst_n = 1'b0;
      #1;
      chk("s6_async_rst", {ov[0], busy_v[0], sel_v[0], od[0], done_v[0]}, 15'h0);
      q.delete();
      @(posedge clk); #1 start_v[0] = 1'b1;
      @(posedge clk); #1 start_v[0] = 1'b0;
      @(negedge clk);
      chk("s6_start_in_rst", {ov[0], busy_v[0]}, 2'b00);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("s6_idle_after_rel", {ov[0], busy_v[0], sel_v[0]}, 6'h0);
      push_frame(1, 15);
      run(0, 0, 0, 0, nb, nbusy, nd, gap);
      chk("s6_bytes", nb, 32);
      chk("s6_done_count", nd, 1);
      chk("s6_queue_empty", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
